// File: rtl/pwm_duty_if.sv
// Button-in / duty-out bundle between the front panel logic and the PWM duty controller.
interface pwm_duty_if #(
    parameter int DUTY_W = 4
);
    logic              ena;
    logic              btn_inc;
    logic              btn_dec;
    logic [DUTY_W-1:0] duty;
    logic              duty_upd;
    logic              inc_db;
    logic              dec_db;

    modport master (
        output ena, btn_inc, btn_dec,
        input  duty, duty_upd, inc_db, dec_db
    );

    modport slave (
        input  ena, btn_inc, btn_dec,
        output duty, duty_upd, inc_db, dec_db
    );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// Button synchroniser/debouncer plus single-step and auto-repeat FSM driving a
// saturating duty register for the downstream PWM stage.
module pwm_duty_ctrl #(
    parameter int DUTY_W       = 4,
    parameter int MAX_DUTY     = 10,
    parameter int INIT_DUTY    = 5,
    parameter int DEB_CYCLES   = 4,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    pwm_duty_if.slave  bus
);
    localparam int DCW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int RCW = $clog2((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        BLOCK  = 2'd3
    } state_t;

    // index 0 = increase button, index 1 = decrease button
    logic [1:0]        sync1_r, sync2_r, db_r, db_q_r;
    logic [DCW-1:0]    deb_cnt_r [2];
    state_t            state_r, state_s;
    logic              dir_r, dir_s;        // 1 = decrease direction held
    logic [RCW-1:0]    rpt_cnt_r, rpt_cnt_s;
    logic              step_up_s, step_dn_s;
    logic [DUTY_W-1:0] duty_r;
    logic              duty_upd_r;

    logic inc_s, dec_s, inc_rise_s, dec_rise_s, held_s, other_s;
    assign inc_s      = db_r[0];
    assign dec_s      = db_r[1];
    assign inc_rise_s = db_r[0] & ~db_q_r[0];
    assign dec_rise_s = db_r[1] & ~db_q_r[1];
    assign held_s     = dir_r ? dec_s : inc_s;
    assign other_s    = dir_r ? inc_s : dec_s;

    // Two-flop synchronisers and per-button debounce counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r      <= 2'b00;
            sync2_r      <= 2'b00;
            db_r         <= 2'b00;
            db_q_r       <= 2'b00;
            deb_cnt_r[0] <= {DCW{1'b0}};
            deb_cnt_r[1] <= {DCW{1'b0}};
        end else begin
            sync1_r <= {bus.btn_dec, bus.btn_inc};
            sync2_r <= sync1_r;
            db_q_r  <= db_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    deb_cnt_r[i] <= {DCW{1'b0}};
                end else if (deb_cnt_r[i] == DCW'(DEB_CYCLES - 1)) begin
                    db_r[i]      <= sync2_r[i];
                    deb_cnt_r[i] <= {DCW{1'b0}};
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DCW'(1);
                end
            end
        end
    end

    // Step FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            dir_r     <= 1'b0;
            rpt_cnt_r <= {RCW{1'b0}};
        end else begin
            state_r   <= state_s;
            dir_r     <= dir_s;
            rpt_cnt_r <= rpt_cnt_s;
        end
    end

    // Step FSM next state and step requests; a second button always wins over repeat
    always_comb begin
        state_s   = state_r;
        dir_s     = dir_r;
        rpt_cnt_s = rpt_cnt_r;
        step_up_s = 1'b0;
        step_dn_s = 1'b0;
        if (!bus.ena) begin
            state_s   = IDLE;
            rpt_cnt_s = {RCW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    rpt_cnt_s = {RCW{1'b0}};
                    if (inc_s && dec_s) begin
                        state_s = BLOCK;
                    end else if (inc_rise_s) begin
                        step_up_s = 1'b1;
                        dir_s     = 1'b0;
                        state_s   = DELAY;
                    end else if (dec_rise_s) begin
                        step_dn_s = 1'b1;
                        dir_s     = 1'b1;
                        state_s   = DELAY;
                    end else begin
                        state_s = IDLE;
                    end
                end
                DELAY, REPEAT: begin
                    if (other_s) begin
                        state_s = BLOCK;
                    end else if (!held_s) begin
                        state_s = IDLE;
                    end else if (rpt_cnt_r == ((state_r == DELAY) ? RCW'(REPEAT_DELAY - 1)
                                                                  : RCW'(REPEAT_RATE - 1))) begin
                        step_up_s = ~dir_r;
                        step_dn_s = dir_r;
                        state_s   = REPEAT;
                        rpt_cnt_s = {RCW{1'b0}};
                    end else begin
                        rpt_cnt_s = rpt_cnt_r + RCW'(1);
                    end
                end
                BLOCK: begin
                    if (!inc_s && !dec_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = BLOCK;
                    end
                end
                default: begin
                    state_s   = IDLE;
                    rpt_cnt_s = {RCW{1'b0}};
                end
            endcase
        end
    end

    // Saturating duty register; a step that cannot move duty does not pulse duty_upd
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_r     <= DUTY_W'(INIT_DUTY);
            duty_upd_r <= 1'b0;
        end else if (step_up_s && (duty_r < DUTY_W'(MAX_DUTY))) begin
            duty_r     <= duty_r + DUTY_W'(1);
            duty_upd_r <= 1'b1;
        end else if (step_dn_s && (duty_r != DUTY_W'(0))) begin
            duty_r     <= duty_r - DUTY_W'(1);
            duty_upd_r <= 1'b1;
        end else begin
            duty_upd_r <= 1'b0;
        end
    end

    assign bus.duty     = duty_r;
    assign bus.duty_upd = duty_upd_r;
    assign bus.inc_db   = db_r[0];
    assign bus.dec_db   = db_r[1];
endmodule
